// File: rtl/gray_code_counter_updown.sv
// Up/down Gray code counter with clear, load, enable and wrap/saturate boundary mode.
// The Gray register is the primary state; a parallel binary register tracks it on the same edge.
module gray_code_counter_updown #(
  parameter int WIDTH = 8,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] cnt_gray,
  output logic [WIDTH-1:0] cnt_bin,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] MIN_VAL = '0;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] next_bin;
  logic [WIDTH-1:0] next_gray;
  logic             next_wrap;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_bin  = cnt_bin;
    next_wrap = 1'b0;
    if (clr) begin
      next_bin = MIN_VAL;
    end else if (load) begin
      next_bin = load_value;
    end else if (en) begin
      if (dir) begin
        if (cnt_bin != MAX_VAL) begin
          next_bin = cnt_bin + ONE;
        end else if (WRAP) begin
          next_bin  = MIN_VAL;
          next_wrap = 1'b1;
        end
      end else begin
        if (cnt_bin != MIN_VAL) begin
          next_bin = cnt_bin - ONE;
        end else if (WRAP) begin
          next_bin  = MAX_VAL;
          next_wrap = 1'b1;
        end
      end
    end
  end

  // Adjacent binary values always map to Gray codes one bit apart.
  assign next_gray = next_bin ^ (next_bin >> 1);

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_gray <= '0;
      cnt_bin  <= '0;
      wrap     <= 1'b0;
    end else begin
      cnt_gray <= next_gray;
      cnt_bin  <= next_bin;
      wrap     <= next_wrap;
    end
  end

  assign at_max = (cnt_bin == MAX_VAL);
  assign at_min = (cnt_bin == MIN_VAL);

endmodule

// File: tb/tb_gray_code_counter_updown.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
// dut_w runs in wrap mode, dut_s in saturate mode; both share the same inputs.
module tb_gray_code_counter_updown;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, dir = 1'b0, clr = 1'b0, load = 1'b0;
  logic [3:0] load_value = 4'h0;

  logic [3:0] gray_w, bin_w, gray_s, bin_s;
  logic       max_w, min_w, wrap_w, max_s, min_s, wrap_s;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    bit         sel;   // 0: dut_w, 1: dut_s
    logic [3:0] gray;
    logic [3:0] bin;
    logic       wrap;
  } exp_t;

  exp_t exp_q[$];

  gray_code_counter_updown #(.WIDTH(4), .WRAP(1'b1)) dut_w (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_value(load_value), .cnt_gray(gray_w), .cnt_bin(bin_w),
    .at_max(max_w), .at_min(min_w), .wrap(wrap_w)
  );

  gray_code_counter_updown #(.WIDTH(4), .WRAP(1'b0)) dut_s (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_value(load_value), .cnt_gray(gray_s), .cnt_bin(bin_s),
    .at_max(max_s), .at_min(min_s), .wrap(wrap_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: outputs settle after the posedge; compare on the following negedge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (!e.sel) begin
        check({e.name, ".gray"},   gray_w, e.gray);
        check({e.name, ".bin"},    bin_w,  e.bin);
        check({e.name, ".wrap"},   wrap_w, e.wrap);
        check({e.name, ".at_max"}, max_w,  e.bin == 4'hF);
        check({e.name, ".at_min"}, min_w,  e.bin == 4'h0);
      end else begin
        check({e.name, ".gray"},   gray_s, e.gray);
        check({e.name, ".bin"},    bin_s,  e.bin);
        check({e.name, ".wrap"},   wrap_s, e.wrap);
        check({e.name, ".at_max"}, max_s,  e.bin == 4'hF);
        check({e.name, ".at_min"}, min_s,  e.bin == 4'h0);
      end
    end
  end

  task automatic step(input string name, input bit sel,
                      input logic e, input logic d, input logic c, input logic l,
                      input logic [3:0] lv,
                      input logic [3:0] g, input logic [3:0] b, input logic w);
    exp_t x;
    @(negedge clk);
    #1;
    en = e; dir = d; clr = c; load = l; load_value = lv;
    x.name = name; x.sel = sel; x.gray = g; x.bin = b; x.wrap = w;
    exp_q.push_back(x);
  endtask

  // Hold inputs idle and wait for the monitor to drain the queue, with a cycle budget.
  task automatic flush();
    int n;
    @(negedge clk);
    #1;
    en = 1'b0; dir = 1'b0; clr = 1'b0; load = 1'b0; load_value = 4'h0;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("flush_queue_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] gseq [16];
    gseq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
             4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    // Reset state
    #12;
    check("reset.gray_w", gray_w, 4'h0);
    check("reset.bin_w",  bin_w,  4'h0);
    check("reset.wrap_w", wrap_w, 1'b0);
    check("reset.min_w",  min_w,  1'b1);
    check("reset.max_w",  max_w,  1'b0);
    check("reset.gray_s", gray_s, 4'h0);
    check("reset.min_s",  min_s,  1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Up count through full cycle with wrap back to 0
    for (int i = 0; i < 16; i++) begin
      int nx;
      nx = (i + 1) % 16;
      step($sformatf("up%0d", i), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0,
           gseq[nx], 4'(nx), (i == 15));
    end

    // Down wrap from 0, then one more step down, then hold
    step("dnwrap0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h8, 4'hF, 1'b1);
    step("dnwrap1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h9, 4'hE, 1'b0);
    step("hold",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h9, 4'hE, 1'b0);

    // Priority: clr over load over en
    step("prio_clr",  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h9, 4'h0, 4'h0, 1'b0);
    step("prio_load", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h9, 4'hD, 4'h9, 1'b0);
    step("prio_en",   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 4'hA, 1'b0);

    // Direction toggling from 5, one step per cycle
    step("tog_load", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h5, 4'h7, 4'h5, 1'b0);
    step("tog_up0",  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h5, 4'h6, 1'b0);
    step("tog_dn0",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h7, 4'h5, 1'b0);
    step("tog_up1",  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h5, 4'h6, 1'b0);
    step("tog_dn1",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h7, 4'h5, 1'b0);
    flush();

    // Saturate mode on dut_s
    step("sat_load15", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 4'h8, 4'hF, 1'b0);
    step("sat_up0",    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h8, 4'hF, 1'b0);
    step("sat_up1",    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h8, 4'hF, 1'b0);
    step("sat_up2",    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h8, 4'hF, 1'b0);
    step("sat_load0",  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
    step("sat_dn0",    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    step("sat_dn1",    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
    flush();

    // Async reset mid-count at 11, then resume counting
    step("ar_load11", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hB, 4'hE, 4'hB, 1'b0);
    flush();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst.gray_w", gray_w, 4'h0);
    check("arst.bin_w",  bin_w,  4'h0);
    check("arst.wrap_w", wrap_w, 1'b0);
    check("arst.min_w",  min_w,  1'b1);
    @(negedge clk);
    rst = 1'b0;
    step("ar_up0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h1, 4'h1, 1'b0);
    step("ar_up1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h3, 4'h2, 1'b0);
    step("ar_up2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h2, 4'h3, 1'b0);
    flush();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gray_code_counter_updown.md
# gray_code_counter_updown

Parametrised up/down Gray code counter with enable, synchronous load and clear, and a selectable wrap or saturate mode. It presents the count as both Gray code and binary, both registered and always consistent. It also flags the count boundaries. It serves clock-domain-crossing pointers, timestamp sources and rate counters that need bidirectional counting or presetting, which a plain free-running Gray counter cannot provide.

## Interface
- WIDTH, default 8: counter width in bits; minimum 2.
- WRAP, default 1: boundary mode. 1 wraps modulo 2^WIDTH; 0 saturates at the boundaries.

- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, asynchronous, active-high
- en  input  1  count enable; one step per cycle while high
- dir  input  1  count direction; 1 counts up, 0 counts down; sampled only when en=1
- clr  input  1  synchronous clear to 0
- load  input  1  synchronous load of load_value
- load_value  input  WIDTH  binary preset value
- cnt_gray  output  WIDTH  registered count, Gray code
- cnt_bin  output  WIDTH  registered count, binary; always equals the Gray-to-binary conversion of cnt_gray
- at_max  output  1  high while count = 2^WIDTH-1 (decoded from registers)
- at_min  output  1  high while count = 0 (decoded from registers)
- wrap  output  1  registered one-cycle pulse; high in the cycle after a step that wrapped

## Operation
- Reset (async assert, any time): cnt_gray=0, cnt_bin=0, wrap=0, at_min=1, at_max=0.
- Priority per cycle: clr > load > en > hold.
- clr=1: count becomes 0, wrap becomes 0.
- load=1 (clr=0): cnt_bin becomes load_value and cnt_gray becomes load_value ^ (load_value >> 1); wrap becomes 0.
- en=1 (clr=0, load=0):
  - Up: the next value is count+1.
  - Down: the next value is count-1.
- Hold (en=0 and no clr or load): all registers unchanged, wrap becomes 0.
- Wrap mode (WRAP=1):
  - Up from 2^WIDTH-1 gives 0.
  - Down from 0 gives 2^WIDTH-1.
  - Both set wrap=1 for exactly one cycle.
- Saturate mode (WRAP=0):
  - Up at 2^WIDTH-1 holds.
  - Down at 0 holds.
  - wrap is never asserted.
- Single-bit-change rule: every count step, up or down, changes exactly one bit of cnt_gray. On a held or saturated step, zero bits change. Load and clear may change any number of bits.
- The Gray code register is the primary state and must be glitch-free (a direct flop output, no logic after it) for CDC use. cnt_bin may be a second register updated in the same edge.
- Arithmetic is modulo 2^WIDTH. There are no X-propagating paths; load_value is used only when load=1.

## Timing
- Latency: a change on en/dir/clr/load is visible on cnt_gray/cnt_bin one cycle later.
- cnt_gray and cnt_bin update on the same clock edge; they never disagree in any cycle.
- at_max/at_min change in the same cycle as the count registers.
- wrap is aligned with the cycle in which the wrapped value first appears on the outputs.
- A wrap is only possible as the result of an en step, so wrap cannot coincide with clr or load.
- Reset deasserts asynchronously; the first count step occurs on the first rising edge where rst=0 and en=1. Deassertion synchronisation is the integrator's responsibility.
- Throughput: one step per cycle, with no bubbles under continuous en=1. This holds across direction reversals: dir flipping every cycle is honoured every cycle.

## Test plan
All scenarios use WIDTH=4.
- Reset then up count: en=1, dir=1 for 16 cycles.
  - cnt_gray must follow 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8, then 0; cnt_bin must follow 0..15, then 0.
  - wrap=1 only in the cycle showing 0 after 8; exactly one Gray bit changes per step.
- Down wrap, WRAP=1: count at 0, en=1, dir=0.
  - Next cycle: cnt_bin=15, cnt_gray=8, wrap=1, at_max=1.
  - The following step gives cnt_bin=14, cnt_gray=9, wrap=0.
- Saturate, WRAP=0:
  - Load 15, then up for 3 cycles: cnt_bin stays 15, cnt_gray=8, wrap=0.
  - Load 0, then down: cnt_bin stays 0, at_min=1.
- Priority: one cycle with clr=1, load=1, load_value=9, en=1 gives cnt_bin=0.
  - Next cycle with load=1 only gives cnt_bin=9, cnt_gray=D.
  - Next cycle with en=1, dir=1 gives cnt_bin=10, cnt_gray=F.
- Direction toggling: from 5, en=1 with dir toggling 1,0,1,0.
  - cnt_bin must read 6,5,6,5 and cnt_gray must read 5,7,5,7.
- Async reset mid-count: assert rst between clock edges while count=11.
  - cnt_gray=0, cnt_bin=0 and wrap=0 immediately, before the next edge.
  - After release with en=1, counting resumes 1,2,… from the first edge.
